// File: rtl/time_unit_mgr.sv
// -----------------------------------------------------------------------------
// time_unit_mgr
//   Host-side time base. It divides clk into time units, keeps the FPGA time
//   count, flags when FPGA time has run ahead of the host-reported time, and
//   emits periodic heartbeat (HB) words upstream on a valid/ack channel.
//
// Parameters
//   N_TM_time         width of time counts (time, HB payload, HB period)
//   N_TM_unit         width of unit_len
//
// Ports
//   clk               in   system clock
//   reset             in   synchronous, active-high reset
//   unit_len          in   clk cycles per time unit (0 behaves as 1)
//   PC_time_elapsed   in   host-reported time, in units
//   send_HB_up_every  in   HB period in units (0 disables HB)
//   reset_time        in   level: while high all time state is held at zero
//   time_unit_pulse   out  one-cycle strobe at each time-unit boundary
//   time_elapsed      out  FPGA time in units (wraps modulo 2^N_TM_time)
//   stall_dn          out  high when time_elapsed > PC_time_elapsed
//   HB_up_d           out  HB payload (time at HB generation)
//   HB_up_v           out  HB valid
//   HB_up_a           in   HB ack from upstream
//   HB_dropped        out  one-cycle strobe: a pending HB was overwritten
// -----------------------------------------------------------------------------
module time_unit_mgr #(
    parameter int N_TM_time = 48,
    parameter int N_TM_unit = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_TM_unit-1:0] unit_len,
    input  logic [N_TM_time-1:0] PC_time_elapsed,
    input  logic [N_TM_time-1:0] send_HB_up_every,
    input  logic                 reset_time,
    output logic                 time_unit_pulse,
    output logic [N_TM_time-1:0] time_elapsed,
    output logic                 stall_dn,
    output logic [N_TM_time-1:0] HB_up_d,
    output logic                 HB_up_v,
    input  logic                 HB_up_a,
    output logic                 HB_dropped
);

    localparam logic [N_TM_unit-1:0] UNIT_ZERO = N_TM_unit'(0);
    localparam logic [N_TM_unit-1:0] UNIT_ONE  = N_TM_unit'(1);
    localparam logic [N_TM_time-1:0] TIME_ZERO = N_TM_time'(0);
    localparam logic [N_TM_time-1:0] TIME_ONE  = N_TM_time'(1);

    // State registers
    logic [N_TM_unit-1:0] clk_ctr_r;
    logic [N_TM_time-1:0] hb_ctr_r;
    logic [N_TM_time-1:0] time_r;
    logic                 pulse_r;
    logic [N_TM_time-1:0] hb_d_r;
    logic                 hb_v_r;
    logic                 hb_drop_r;

    // Next-state / decode signals
    logic [N_TM_unit-1:0] eff_len_s;
    logic                 unit_wrap_s;
    logic                 hb_off_s;
    logic                 hb_wrap_s;
    logic                 hb_gen_s;
    logic                 hb_xfer_s;
    logic [N_TM_time-1:0] time_inc_s;
    logic [N_TM_unit-1:0] clk_ctr_nxt_s;
    logic [N_TM_time-1:0] hb_ctr_nxt_s;
    logic [N_TM_time-1:0] time_nxt_s;
    logic                 pulse_nxt_s;
    logic [N_TM_time-1:0] hb_d_nxt_s;
    logic                 hb_v_nxt_s;
    logic                 hb_drop_nxt_s;

    // Divider and heartbeat-period decode.
    // The ">=" compares (rather than "==") make a config value that shrinks
    // below the running count wrap on the next opportunity instead of running
    // away through the whole counter range.
    always_comb begin
        eff_len_s   = (unit_len == UNIT_ZERO) ? UNIT_ONE : unit_len;
        unit_wrap_s = (clk_ctr_r >= (eff_len_s - UNIT_ONE));
        hb_off_s    = (send_HB_up_every == TIME_ZERO);
        hb_wrap_s   = (hb_ctr_r >= (send_HB_up_every - TIME_ONE));
        time_inc_s  = time_r + TIME_ONE;
        hb_xfer_s   = hb_v_r & HB_up_a;
    end

    // Next-state for the time counters; reset_time freezes everything at zero.
    always_comb begin
        clk_ctr_nxt_s = clk_ctr_r;
        hb_ctr_nxt_s  = hb_ctr_r;
        time_nxt_s    = time_r;
        pulse_nxt_s   = 1'b0;
        hb_gen_s      = 1'b0;
        if (reset_time) begin
            clk_ctr_nxt_s = UNIT_ZERO;
            hb_ctr_nxt_s  = TIME_ZERO;
            time_nxt_s    = TIME_ZERO;
            pulse_nxt_s   = 1'b0;
            hb_gen_s      = 1'b0;
        end else if (unit_wrap_s) begin
            clk_ctr_nxt_s = UNIT_ZERO;
            pulse_nxt_s   = 1'b1;
            time_nxt_s    = time_inc_s;
            // HB counter only advances on unit boundaries.
            if (hb_off_s) begin
                hb_ctr_nxt_s = TIME_ZERO;
                hb_gen_s     = 1'b0;
            end else if (hb_wrap_s) begin
                hb_ctr_nxt_s = TIME_ZERO;
                hb_gen_s     = 1'b1;
            end else begin
                hb_ctr_nxt_s = hb_ctr_r + TIME_ONE;
                hb_gen_s     = 1'b0;
            end
        end else begin
            clk_ctr_nxt_s = clk_ctr_r + UNIT_ONE;
            pulse_nxt_s   = 1'b0;
            hb_gen_s      = 1'b0;
        end
    end

    // One-entry, latest-wins HB holding register.
    // A new HB replacing an unacked one is reported as a drop; a new HB in the
    // same cycle as an ack replaces a word that has just been taken, so it is
    // not a drop and valid simply stays high.
    always_comb begin
        hb_v_nxt_s    = hb_v_r;
        hb_d_nxt_s    = hb_d_r;
        hb_drop_nxt_s = 1'b0;
        if (hb_gen_s) begin
            hb_v_nxt_s    = 1'b1;
            hb_d_nxt_s    = time_inc_s;
            hb_drop_nxt_s = hb_v_r & ~HB_up_a;
        end else if (hb_xfer_s) begin
            hb_v_nxt_s    = 1'b0;
            hb_d_nxt_s    = hb_d_r;
            hb_drop_nxt_s = 1'b0;
        end else begin
            hb_v_nxt_s    = hb_v_r;
            hb_d_nxt_s    = hb_d_r;
            hb_drop_nxt_s = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_ctr_r <= UNIT_ZERO;
            hb_ctr_r  <= TIME_ZERO;
            time_r    <= TIME_ZERO;
            pulse_r   <= 1'b0;
            hb_d_r    <= TIME_ZERO;
            hb_v_r    <= 1'b0;
            hb_drop_r <= 1'b0;
        end else begin
            clk_ctr_r <= clk_ctr_nxt_s;
            hb_ctr_r  <= hb_ctr_nxt_s;
            time_r    <= time_nxt_s;
            pulse_r   <= pulse_nxt_s;
            hb_d_r    <= hb_d_nxt_s;
            hb_v_r    <= hb_v_nxt_s;
            hb_drop_r <= hb_drop_nxt_s;
        end
    end

    assign time_unit_pulse = pulse_r;
    assign time_elapsed    = time_r;
    assign HB_up_d         = hb_d_r;
    assign HB_up_v         = hb_v_r;
    assign HB_dropped      = hb_drop_r;
    // Plain unsigned compare: after time wraps to zero the stall clears.
    assign stall_dn        = (time_r > PC_time_elapsed);

endmodule
